rle_decoder: RTL

Downstream companion to the RLE compressor: reads run words from the compressed-word RAM and expands each into a byte stream on a valid/ready output. Sits between the compressed-word RAM read port and any byte consumer (verification scoreboard, UART, output RAM writer). Processes a programmed number of words starting at a programmed address, then pulses `done`.

---
 rtl/rle_pkg.sv | 22 ++
 rtl/rle_decoder_if.sv | 13 +
 rtl/rle_word_unpack.sv | 19 +
 rtl/rle_decoder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared word format and FSM encoding for the RLE compressor/decoder pair.
// A run word carries the data byte in [7:0] and the run count in [15:8].
package rle_pkg;

  localparam int DATA_W    = 8;
  localparam int COUNT_W   = 8;
  localparam int ADDR_W    = 10;
  localparam int WORD_W    = 32;
  localparam int DATA_LSB  = 0;
  localparam int COUNT_LSB = 8;
  localparam int WCNT_W    = ADDR_W + 1;
  localparam int CSUM_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EXPAND = 3'd3,
    ST_DONE   = 3'd4
  } rle_dec_state_e;

endpackage

// File: rtl/rle_decoder_if.sv
// Byte-stream valid/ready channel between the RLE decoder and a byte consumer.
// The decoder drives through the master modport; the consumer uses slave.
interface rle_decoder_if;
  import rle_pkg::*;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/rle_word_unpack.sv
// Combinational split of a compressed run word into data byte, run count
// and an empty-run flag. Bits above the count field are reserved.
module rle_word_unpack
  import rle_pkg::*;
(
  input  logic [WORD_W-1:0]  word_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               is_empty_o
);

  logic unused_hi_s;

  assign data_o      = word_i[DATA_LSB +: DATA_W];
  assign count_o     = word_i[COUNT_LSB +: COUNT_W];
  assign is_empty_o  = (count_o == {COUNT_W{1'b0}});
  assign unused_hi_s = ^word_i[WORD_W-1:COUNT_LSB+COUNT_W];

endmodule

// File: rtl/rle_decoder.sv
// RLE decoder: fetches run words from a 1-cycle synchronous RAM and expands
// each into a valid/ready byte stream. Optional RLE_DEC_CHECKSUM_EN adds a checksum port.
module rle_decoder
  import rle_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [WCNT_W-1:0]  num_words,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_q,
`ifdef RLE_DEC_CHECKSUM_EN
  output logic [CSUM_W-1:0]  checksum,
`endif
  rle_decoder_if.master      out_if
);

  rle_dec_state_e     state_q, state_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WCNT_W-1:0]  words_left_q, words_left_d;
  logic [COUNT_W-1:0] run_left_q, run_left_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;

  logic [DATA_W-1:0]  word_data_s;
  logic [COUNT_W-1:0] word_count_s;
  logic               word_empty_s;
  logic               xfer_s;

  rle_word_unpack u_unpack (
    .word_i     (mem_q),
    .data_o     (word_data_s),
    .count_o    (word_count_s),
    .is_empty_o (word_empty_s)
  );

  assign xfer_s = valid_q & out_if.out_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_q   <= {ADDR_W{1'b0}};
      words_left_q <= {WCNT_W{1'b0}};
      run_left_q   <= {COUNT_W{1'b0}};
      data_q       <= {DATA_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      words_left_q <= words_left_d;
      run_left_q   <= run_left_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    words_left_d = words_left_q;
    run_left_d   = run_left_q;
    data_d       = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mem_addr_d   = start_addr;
          words_left_d = num_words;
          if (num_words == {WCNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // words_left_q is at least 1 here, so the decrement cannot underflow
        data_d       = word_data_s;
        run_left_d   = word_count_s;
        words_left_d = words_left_q - 11'd1;
        mem_addr_d   = mem_addr_q + 10'd1;
        if (word_empty_s) begin
          if (words_left_q != 11'd1) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (xfer_s) begin
          run_left_d = run_left_q - 8'd1;
          if (run_left_q == 8'd1) begin
            if (words_left_q != 11'd0) begin
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_EXPAND;
          end
        end else begin
          state_d = ST_EXPAND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs leave a register
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    valid_d = (state_d == ST_EXPAND);
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign mem_addr         = mem_addr_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;

`ifdef RLE_DEC_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q, csum_d;

  // Checksum of transferred bytes, cleared by an accepted start
  always_comb begin
    if ((state_q == ST_IDLE) && start) begin
      csum_d = {CSUM_W{1'b0}};
    end else if (xfer_s) begin
      csum_d = csum_q + {8'h00, data_q};
    end else begin
      csum_d = csum_q;
    end
  end

  // Checksum register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_q <= {CSUM_W{1'b0}};
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
